// File: rtl/eth_link_sequencer.sv
// Bring-up and supervision FSM for one 10G QSFP28 lane: module reset, GT reset_all, done/lock wait, retrain.
// Optional macro ETH_LINK_SEQ_BER_RETRAIN_EN adds retrain on sustained rx_high_ber while the link is up.
module eth_link_sequencer #(
  parameter int unsigned MOD_RESET_CYCLES = 1250,
  parameter int unsigned MOD_INIT_CYCLES  = 250000,
  parameter int unsigned GT_RESET_CYCLES  = 16,
  parameter int unsigned DONE_TIMEOUT     = 1250000,
  parameter int unsigned LOCK_TIMEOUT     = 1250000,
  parameter int unsigned LOCK_DEBOUNCE    = 125,
  parameter int unsigned BER_CYCLES       = 12500
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       mod_present_n,
  input  logic       gt_reset_tx_done,
  input  logic       gt_reset_rx_done,
  input  logic       rx_block_lock,
  input  logic       rx_high_ber,
  output logic       gt_reset_all,
  output logic       qsfp_resetl,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] retrain_count
);

  // state     | meaning
  // IDLE      | no module (or reset just released); module and GT held in reset
  // MOD_RST   | qsfp_resetl pulse low
  // MOD_INIT  | module out of reset, waiting for its init time
  // GT_RST    | gt_reset_all pulse high
  // WAIT_DONE | waiting for GT tx/rx reset-done, with timeout
  // WAIT_LOCK | waiting for debounced PCS block lock, with timeout
  // UP        | link usable; watching for lock/done loss
  // RETRAIN   | single cycle, bumps retrain_count, re-runs GT reset
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MOD_RST   = 3'd1;
  localparam logic [2:0] MOD_INIT  = 3'd2;
  localparam logic [2:0] GT_RST    = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] WAIT_LOCK = 3'd5;
  localparam logic [2:0] UP        = 3'd6;
  localparam logic [2:0] RETRAIN   = 3'd7;

  localparam logic [23:0] DEB_LOAD = 24'(LOCK_DEBOUNCE - 1);

  logic [1:0]  rst_q;
  logic [1:0]  prs_q;
  logic [1:0]  txd_q;
  logic [1:0]  rxd_q;
  logic [1:0]  lck_q;
  logic        rst_rdy;
  logic        absent;
  logic        both_done;
  logic        lock;
  logic [2:0]  state_nx;
  logic [23:0] timer;
  logic [23:0] tmr_load;
  logic        tmr_zero;
  logic [23:0] deb_cnt;
  logic        deb_cond;
  logic        deb_hit;
  logic        ber_hit;

  // rst_q holds the FSM in IDLE until the synchronizers carry real input values
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rst_q <= '0;
      prs_q <= '0;
      txd_q <= '0;
      rxd_q <= '0;
      lck_q <= '0;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
      prs_q <= {prs_q[0], mod_present_n};
      txd_q <= {txd_q[0], gt_reset_tx_done};
      rxd_q <= {rxd_q[0], gt_reset_rx_done};
      lck_q <= {lck_q[0], rx_block_lock};
    end
  end

  assign rst_rdy   = rst_q[1];
  assign absent    = prs_q[1];
  assign both_done = txd_q[1] & rxd_q[1];
  assign lock      = lck_q[1];
  assign tmr_zero  = (timer == '0);

`ifdef ETH_LINK_SEQ_BER_RETRAIN_EN
  localparam logic [23:0] BER_LOAD = 24'(BER_CYCLES - 1);

  logic [1:0]  ber_q;
  logic [23:0] ber_cnt;
  logic        ber_cond;

  assign ber_cond = (state == UP) && ber_q[1];
  assign ber_hit  = ber_cond && (ber_cnt == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ber_q   <= '0;
      ber_cnt <= BER_LOAD;
    end else begin
      ber_q <= {ber_q[0], rx_high_ber};
      if ((state_nx != state) || !ber_cond) ber_cnt <= BER_LOAD;
      else if (ber_cnt != '0)               ber_cnt <= ber_cnt - 24'd1;
    end
  end
`else
  logic unused_ber;

  assign unused_ber = rx_high_ber | (BER_CYCLES == 0);
  assign ber_hit    = 1'b0;
`endif

  // Same counter debounces lock acquisition in WAIT_LOCK and lock loss in UP
  always_comb begin
    deb_cond = 1'b0;
    if (state == WAIT_LOCK) deb_cond = lock;
    else if (state == UP)   deb_cond = !lock;
  end

  assign deb_hit = deb_cond && (deb_cnt == '0);

  always_comb begin
    state_nx = state;
    if (absent) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      if (rst_rdy)  state_nx = MOD_RST;
        MOD_RST:   if (tmr_zero) state_nx = MOD_INIT;
        MOD_INIT:  if (tmr_zero) state_nx = GT_RST;
        GT_RST:    if (tmr_zero) state_nx = WAIT_DONE;
        WAIT_DONE: begin
          if (both_done)     state_nx = WAIT_LOCK;
          else if (tmr_zero) state_nx = RETRAIN;
        end
        WAIT_LOCK: begin
          if (deb_hit)       state_nx = UP;
          else if (tmr_zero) state_nx = RETRAIN;
        end
        UP:        if (!both_done || deb_hit || ber_hit) state_nx = RETRAIN;
        RETRAIN:   state_nx = GT_RST;
      endcase
    end
  end

  // Loaded with N-1 so a timed state is visible for exactly N clocks
  always_comb begin
    tmr_load = '0;
    case (state_nx)
      MOD_RST:   tmr_load = 24'(MOD_RESET_CYCLES - 1);
      MOD_INIT:  tmr_load = 24'(MOD_INIT_CYCLES - 1);
      GT_RST:    tmr_load = 24'(GT_RESET_CYCLES - 1);
      WAIT_DONE: tmr_load = 24'(DONE_TIMEOUT - 1);
      WAIT_LOCK: tmr_load = 24'(LOCK_TIMEOUT - 1);
      default:   tmr_load = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      timer         <= '0;
      deb_cnt       <= DEB_LOAD;
      gt_reset_all  <= 1'b1;
      qsfp_resetl   <= 1'b0;
      link_up       <= 1'b0;
      retrain_count <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) timer <= tmr_load;
      else if (!tmr_zero)    timer <= timer - 24'd1;
      if ((state_nx != state) || !deb_cond) deb_cnt <= DEB_LOAD;
      else if (deb_cnt != '0)               deb_cnt <= deb_cnt - 24'd1;
      // Outputs decode the next state so they line up with the state register
      gt_reset_all <= (state_nx == IDLE) || (state_nx == GT_RST);
      qsfp_resetl  <= !((state_nx == IDLE) || (state_nx == MOD_RST));
      link_up      <= (state_nx == UP);
      if ((state == RETRAIN) && (retrain_count != 8'hFF))
        retrain_count <= retrain_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_eth_link_sequencer.sv
// Directed self-checking bench for eth_link_sequencer with shortened timing parameters.
module tb_eth_link_sequencer;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MOD_RST   = 3'd1;
  localparam logic [2:0] MOD_INIT  = 3'd2;
  localparam logic [2:0] GT_RST    = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] WAIT_LOCK = 3'd5;
  localparam logic [2:0] UP        = 3'd6;
  localparam logic [2:0] RETRAIN   = 3'd7;

`ifdef ETH_LINK_SEQ_BER_RETRAIN_EN
  localparam int BER_EXP = 1;
`else
  localparam int BER_EXP = 0;
`endif

  logic       clock;
  logic       resetn;
  logic       mod_present_n;
  logic       gt_reset_tx_done;
  logic       gt_reset_rx_done;
  logic       rx_block_lock;
  logic       rx_high_ber;
  logic       gt_reset_all;
  logic       qsfp_resetl;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retrain_count;

  int n_vec = 0;
  int n_err = 0;

  eth_link_sequencer #(
    .MOD_RESET_CYCLES(8),
    .MOD_INIT_CYCLES (20),
    .GT_RESET_CYCLES (4),
    .DONE_TIMEOUT    (50),
    .LOCK_TIMEOUT    (60),
    .LOCK_DEBOUNCE   (5),
    .BER_CYCLES      (10)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .mod_present_n   (mod_present_n),
    .gt_reset_tx_done(gt_reset_tx_done),
    .gt_reset_rx_done(gt_reset_rx_done),
    .rx_block_lock   (rx_block_lock),
    .rx_high_ber     (rx_high_ber),
    .gt_reset_all    (gt_reset_all),
    .qsfp_resetl     (qsfp_resetl),
    .link_up         (link_up),
    .state           (state),
    .retrain_count   (retrain_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int cyc;
    cyc = 0;
    while (state != s && cyc < budget) begin
      step(1);
      cyc++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
    chk({tag, "_gt"},    32'(gt_reset_all), 1);
    chk({tag, "_qsfp"},  32'(qsfp_resetl), 0);
    chk({tag, "_link"},  32'(link_up), 0);
    chk({tag, "_cnt"},   32'(retrain_count), 0);
  endtask

  // Expects done/lock low on entry; finishes at the first sample in UP
  task automatic bring_up();
    int cyc;
    wait_state("enter_mod_rst", MOD_RST, 10);
    cyc = 0;
    while (state == MOD_RST && cyc < 100) begin
      if (!qsfp_resetl) cyc++;
      step(1);
    end
    chk("mod_rst_width", 32'(cyc), 8);
    chk("mod_init_qsfp", 32'(qsfp_resetl), 1);
    chk("mod_init_gt", 32'(gt_reset_all), 0);
    cyc = 0;
    while (state == MOD_INIT && cyc < 100) begin
      cyc++;
      step(1);
    end
    chk("mod_init_len", 32'(cyc), 20);
    chk("gt_rst_state", 32'(state), 32'(GT_RST));
    cyc = 0;
    while (state == GT_RST && cyc < 100) begin
      if (gt_reset_all) cyc++;
      step(1);
    end
    chk("gt_pulse_width", 32'(cyc), 4);
    chk("wait_done_gt", 32'(gt_reset_all), 0);
    step(9);
    gt_reset_tx_done = 1'b1;
    gt_reset_rx_done = 1'b1;
    step(2);
    chk("done_lat_hold", 32'(state), 32'(WAIT_DONE));
    step(1);
    chk("done_lat", 32'(state), 32'(WAIT_LOCK));
    step(10);
    rx_block_lock = 1'b1;
    step(6);
    chk("lock_deb_hold", 32'(link_up), 0);
    step(1);
    chk("link_up", 32'(link_up), 1);
    chk("up_state", 32'(state), 32'(UP));
  endtask

  initial begin
    int cyc;
    int n;
    logic flag;

    resetn           = 1'b1;
    mod_present_n    = 1'b0;
    gt_reset_tx_done = 1'b0;
    gt_reset_rx_done = 1'b0;
    rx_block_lock    = 1'b0;
    rx_high_ber      = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("por");

    step(2);
    resetn = 1'b1;
    step(2);
    chk("rst_release_idle", 32'(state), 32'(IDLE));

    // clean bring-up
    bring_up();
    chk("clean_cnt", 32'(retrain_count), 0);

    // 3-cycle lock glitch must not drop the link
    rx_block_lock = 1'b0;
    step(3);
    rx_block_lock = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (!link_up) flag = 1'b0;
    end
    chk("glitch_link_up", 32'(flag), 1);

    // 6-cycle lock loss retrains without touching the module reset
    rx_block_lock = 1'b0;
    step(6);
    chk("loss_hold", 32'(link_up), 1);
    rx_block_lock = 1'b1;
    step(1);
    chk("loss_retrain", 32'(state), 32'(RETRAIN));
    chk("loss_link_down", 32'(link_up), 0);
    step(1);
    chk("loss_cnt", 32'(retrain_count), 1);
    cyc = 0;
    flag = 1'b1;
    while (state == GT_RST && cyc < 100) begin
      if (gt_reset_all) cyc++;
      if (!qsfp_resetl) flag = 1'b0;
      step(1);
    end
    chk("loss_gt_pulse", 32'(cyc), 4);
    wait_state("loss_reup", UP, 20);
    chk("loss_qsfp_held", 32'(flag & qsfp_resetl), 1);

    // done loss in UP, then repeated done timeouts
    gt_reset_tx_done = 1'b0;
    gt_reset_rx_done = 1'b0;
    step(2);
    chk("done_loss_hold", 32'(state), 32'(UP));
    step(1);
    chk("done_loss_retrain", 32'(state), 32'(RETRAIN));
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("timeout_cnt", 32'(retrain_count), 32'(2 + k));
      cyc = 1;
      while (state != RETRAIN && cyc < 100) begin
        step(1);
        cyc++;
      end
      chk("timeout_period", 32'(cyc), 55);
    end

    // module removal during WAIT_LOCK
    gt_reset_tx_done = 1'b1;
    gt_reset_rx_done = 1'b1;
    rx_block_lock    = 1'b0;
    wait_state("enter_wait_lock", WAIT_LOCK, 20);
    step(2);
    mod_present_n = 1'b1;
    step(2);
    chk("remove_hold", 32'(state), 32'(WAIT_LOCK));
    step(1);
    chk("remove_idle", 32'(state), 32'(IDLE));
    chk("remove_qsfp", 32'(qsfp_resetl), 0);
    chk("remove_gt", 32'(gt_reset_all), 1);
    chk("remove_link", 32'(link_up), 0);
    gt_reset_tx_done = 1'b0;
    gt_reset_rx_done = 1'b0;
    step(5);
    chk("absent_stays_idle", 32'(state), 32'(IDLE));
    mod_present_n = 1'b0;
    bring_up();
    chk("reinsert_cnt", 32'(retrain_count), 5);

    // 300 retrains to saturate the counter
    gt_reset_tx_done = 1'b0;
    gt_reset_rx_done = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 300 && cyc < 20000) begin
      step(1);
      cyc++;
      if (state == RETRAIN) n++;
    end
    chk("retrain_300", 32'(n), 300);
    gt_reset_tx_done = 1'b1;
    gt_reset_rx_done = 1'b1;
    wait_state("sat_reup", UP, 30);
    chk("sat_cnt", 32'(retrain_count), 255);

    // async reset while UP, between clock edges
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("async_rst");
    gt_reset_tx_done = 1'b0;
    gt_reset_rx_done = 1'b0;
    rx_block_lock    = 1'b0;
    step(3);
    resetn = 1'b1;
    step(2);
    chk("rst2_release_idle", 32'(state), 32'(IDLE));
    bring_up();

    // high BER: 9 cycles is one short, 10 cycles trips when enabled
    rx_high_ber = 1'b1;
    step(9);
    rx_high_ber = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (state == RETRAIN) flag = 1'b1;
    end
    chk("ber_9_no_retrain", 32'(flag), 0);
    rx_high_ber = 1'b1;
    step(10);
    rx_high_ber = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (state == RETRAIN) flag = 1'b1;
    end
    chk("ber_10_retrain", 32'(flag), 32'(BER_EXP));
    chk("ber_cnt", 32'(retrain_count), 32'(BER_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
